// File: rtl/hello_scroller.sv
// hello_scroller
// Holds the 8-entry message ring "HELLO___" and scrolls a NUM_DIGITS-wide window across
// it, one position per prescaler tick while running, or one per rising edge of step while
// paused. Feeds packed 3-bit character codes to downstream HEX decoders.
//   Code map: 000=H, 001=E, 010=L, 011=O, 100=blank.
// Ports:
//   CLOCK_50   in   sole clock, rising edge
//   reset      in   synchronous, active-high, dominant
//   run        in   1=auto-scroll, 0=paused
//   dir        in   0=scroll left (pos+1), 1=scroll right (pos-1)
//   step       in   level; each rising edge advances once while paused
//   char_codes out  digit i at [3i+2:3i]; digit 0 is the rightmost display
//   tick       out  one-cycle pulse on each auto-advance
//   pos        out  current ring offset 0..7
module hello_scroller #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned NUM_DIGITS = 5
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    dir,
  input  logic                    step,
  output logic [3*NUM_DIGITS-1:0] char_codes,
  output logic                    tick,
  output logic [2:0]              pos
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  typedef enum logic [0:0] {StPaused, StRunning} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    tick_q, tick_d;
  logic                    step_q;
  logic [2:0]              pos_q, pos_d;
  logic [3*NUM_DIGITS-1:0] char_codes_q, char_codes_d;

  logic step_edge;
  logic step_adv;
  logic advance;

  function automatic logic [2:0] ring_code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = 3'b000;  // H
      3'd1:    code = 3'b001;  // E
      3'd2,
      3'd3:    code = 3'b010;  // L
      3'd4:    code = 3'b011;  // O
      default: code = 3'b100;  // blank
    endcase
    return code;
  endfunction

  // Leftmost digit shows ring[p], rightmost shows ring[p + NUM_DIGITS - 1].
  function automatic logic [3*NUM_DIGITS-1:0] window(input logic [2:0] p);
    logic [3*NUM_DIGITS-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w[3*i +: 3] = ring_code(p + 3'(NUM_DIGITS - 1 - i));
    end
    return w;
  endfunction

  always_comb begin
    state_d = run ? StRunning : StPaused;

    cnt_d = '0;
    if (state_q == StRunning) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end

    tick_d = (state_q == StRunning) && run && (cnt_q == CntMax);

    // Step edges only count while fully paused; this keeps them exclusive with tick.
    step_edge = step & ~step_q;
    step_adv  = step_edge && (state_q == StPaused) && !run;
    advance   = tick_d || step_adv;

    pos_d = pos_q;
    if (advance) begin
      pos_d = dir ? pos_q - 3'd1 : pos_q + 3'd1;
    end

    char_codes_d = window(pos_d);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= StPaused;
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      step_q       <= 1'b1;  // a step held high through reset is not an edge
      pos_q        <= 3'd0;
      char_codes_q <= window(3'd0);
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      step_q       <= step;
      pos_q        <= pos_d;
      char_codes_q <= char_codes_d;
    end
  end

  assign char_codes = char_codes_q;
  assign tick       = tick_q;
  assign pos        = pos_q;

endmodule

// File: tb/tb_hello_scroller.sv
// Scoreboard bench for hello_scroller (TICK_DIV=4, NUM_DIGITS=5). Stimulus pushes expected
// events (pos, char_codes, tick, cycle); the monitor pops one whenever tick pulses, pos
// changes outside reset, or the stimulus requests a snapshot.
module tb_hello_scroller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        dir = 1'b0;
  logic        step = 1'b0;
  logic [14:0] char_codes;
  logic        tick;
  logic [2:0]  pos;

  hello_scroller #(
    .TICK_DIV   (4),
    .NUM_DIGITS (5)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .run        (run),
    .dir        (dir),
    .step       (step),
    .char_codes (char_codes),
    .tick       (tick),
    .pos        (pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  pos;
    logic [14:0] codes;
    logic        tick;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          probe_req = 0;
  int          probe_seen = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_timeout = 0;
  logic [2:0]  last_pos;
  logic [14:0] win_tbl [8];

  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed windows "HELLO", "ELLO_", "LLO__", "LO___", "O___H", "___HE", "__HEL",
  // "_HELL" for pos 0..7.
  initial begin
    win_tbl[0] = 15'h0293; win_tbl[1] = 15'h149C; win_tbl[2] = 15'h24E4;
    win_tbl[3] = 15'h2724; win_tbl[4] = 15'h3920; win_tbl[5] = 15'h4901;
    win_tbl[6] = 15'h480A; win_tbl[7] = 15'h4052;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   probe_pend;
    probe_pend = (probe_req != probe_seen);
    if (probe_pend || tick || (!reset && pos != last_pos)) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_event: got pos=%0d codes=%h tick=%b cyc=%0d, required none",
                 pos, char_codes, tick, cyc);
      end else begin
        e = sb.pop_front();
        if (pos === e.pos && char_codes === e.codes && tick === e.tick && cyc == e.cyc) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got pos=%0d codes=%h tick=%b cyc=%0d, required pos=%0d codes=%h tick=%b cyc=%0d",
                   e.name, pos, char_codes, tick, cyc, e.pos, e.codes, e.tick, e.cyc);
        end
      end
    end
    if (probe_pend) probe_seen = probe_req;
    last_pos = pos;
  end

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_evt(input string name, input logic [2:0] p, input logic t,
                            input int at);
    exp_t e;
    e.name  = name;
    e.pos   = p;
    e.codes = win_tbl[p];
    e.tick  = t;
    e.cyc   = at;
    sb.push_back(e);
  endtask

  task automatic probe(input string name, input logic [2:0] p);
    expect_evt(name, p, 1'b0, cyc);
    probe_req++;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && probe_seen == probe_req) return;
      step_clk(1);
    end
    $display("FAIL %s_timeout: got %0d pending events, required 0", name, sb.size());
    n_timeout++;
    sb.delete();
    probe_seen = probe_req;
  endtask

  initial begin
    int k;
    // 1. Reset state, held while idle.
    step_clk(2);
    probe("reset_state", 3'd0);
    reset = 1'b0;
    step_clk(3);
    probe("idle_hold", 3'd0);
    drain("t1", 5);

    // 2/3. Scroll left through all 8 positions back to "HELLO".
    run = 1'b1;
    k = cyc;
    for (int j = 0; j < 8; j++) begin
      expect_evt($sformatf("left_tick%0d", j), 3'((j + 1) % 8), 1'b1, k + 5 + 4 * j);
    end
    drain("t2", 60);
    run = 1'b0;
    step_clk(3);

    // 4. From reset, scroll right: 0 wraps to 7.
    reset = 1'b1;
    step_clk(2);
    reset = 1'b0;
    run   = 1'b1;
    dir   = 1'b1;
    k = cyc;
    expect_evt("right_wrap", 3'd7, 1'b1, k + 5);
    expect_evt("right_tick2", 3'd6, 1'b1, k + 9);
    drain("t4", 30);
    run = 1'b0;
    dir = 1'b0;
    step_clk(3);

    // 5. Manual step while paused: one advance per rising edge.
    reset = 1'b1;
    step_clk(2);
    reset = 1'b0;
    step_clk(2);
    k = cyc;
    step = 1'b1;
    expect_evt("step_edge1", 3'd1, 1'b0, k + 1);
    step_clk(3);
    step = 1'b0;
    step_clk(1);
    step = 1'b1;
    expect_evt("step_edge2", 3'd2, 1'b0, k + 5);
    step_clk(2);
    drain("t5a", 10);
    step = 1'b0;
    step_clk(1);

    // Step edges with run=1 are ignored, including one coinciding with a tick.
    run  = 1'b1;
    step = 1'b1;
    k = cyc;
    expect_evt("step_vs_tick", 3'd3, 1'b1, k + 5);
    step_clk(3);
    step = 1'b0;
    step_clk(1);
    step = 1'b1;
    drain("t5b", 20);
    run = 1'b0;
    step_clk(3);

    // Step held high across reset must not advance.
    reset = 1'b1;
    step_clk(2);
    reset = 1'b0;
    step_clk(3);
    probe("step_held_reset", 3'd0);
    drain("t5c", 5);
    step = 1'b0;
    step_clk(1);

    // 6. Reset while running with cnt=2.
    step = 1'b1;
    expect_evt("pre_reset_step", 3'd1, 1'b0, cyc + 1);
    step_clk(1);
    step = 1'b0;
    step_clk(1);
    drain("t6a", 5);
    run = 1'b1;
    step_clk(3);
    reset = 1'b1;
    step_clk(1);
    probe("mid_reset", 3'd0);
    reset = 1'b0;
    k = cyc;
    expect_evt("post_reset_tick", 3'd1, 1'b1, k + 5);
    drain("t6b", 20);
    run = 1'b0;
    step_clk(10);
    drain("final", 5);

    $display("%0d/%0d checks passed", n_pass, n_checks + n_timeout);
    $finish;
  end

endmodule
